spi_keys_regmap: RTL and testbench

//  Successor to the fixed 68-key SPI readout: sampled, debounced key state with per-key change latches,

---
 rtl/spi_keys_regmap.sv | 138 +++++++++++++
 tb/tb_spi_keys_regmap.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_keys_regmap.sv
// Debounced key state with per-key change latches, read through an auto-incrementing SPI register map.
// Latency: SPI byte strobe to spi_tx_byte_o is 1 cycle; irq_o follows change-latch updates by 1 cycle.
// Backpressure: none; every strobe seen with chip select low is serviced the cycle after it arrives.
module spi_keys_regmap #(
    parameter int NUM_KEYS   = 68,
    parameter int SAMPLE_DIV = 7500,
    parameter int DEBOUNCE   = 4
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    input  logic                spi_cs_i,
    input  logic                spi_rx_valid_i,
    input  logic [7:0]          spi_rx_byte_i,
    output logic [7:0]          spi_tx_byte_o,
    output logic                irq_o,
    output logic                sample_tick_o
);
    localparam int GROUPS = (NUM_KEYS + 7) / 8;
    localparam int PADW   = GROUPS * 8;
    localparam int DIVW   = $clog2(SAMPLE_DIV);

    typedef logic [DEBOUNCE-1:0] hist_t;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [DIVW-1:0]     div_q, div_d;
    logic                tick;
    hist_t               hist_q [NUM_KEYS];
    hist_t               hist_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] state_q, state_d, chg_q, chg_d, flip, clr;
    logic                irq_q, tick_q;
    logic                mid_frame_q;
    logic [7:0]          addr_q, tx_q, rd_addr, rd_dat;
    logic                rd_vld;
    logic [PADW-1:0]     state_pad, chg_pad;
    logic [8:0]          chg_cnt;

    always_comb begin
        tick  = (div_q == DIVW'(SAMPLE_DIV - 1));
        div_d = tick ? '0 : div_q + DIVW'(1);
    end

    // A key only changes level once its whole history window agrees.
    always_comb begin
        state_d = state_q;
        flip    = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            hist_d[k] = hist_q[k];
            if (tick) begin
                hist_d[k] = hist_t'({hist_q[k], sync2_q[k]});
                if ((&hist_d[k]) && !state_q[k]) begin
                    state_d[k] = 1'b1;
                    flip[k]    = 1'b1;
                end else if (!(|hist_d[k]) && state_q[k]) begin
                    state_d[k] = 1'b0;
                    flip[k]    = 1'b1;
                end
            end
        end
    end

    assign state_pad = PADW'(state_q);
    assign chg_pad   = PADW'(chg_q);
    assign rd_vld    = spi_rx_valid_i && !spi_cs_i;
    assign rd_addr   = mid_frame_q ? addr_q : spi_rx_byte_i;

    always_comb begin
        rd_dat  = 8'h00;
        clr     = '0;
        chg_cnt = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            chg_cnt = chg_cnt + 9'(chg_q[k]);
        end
        for (int g = 0; g < GROUPS; g++) begin
            if (rd_addr == 8'(g)) begin
                rd_dat = state_pad[g*8 +: 8];
            end
            if (rd_addr == 8'(8'h40 + g)) begin
                rd_dat = chg_pad[g*8 +: 8];
                for (int i = 0; i < 8; i++) begin
                    if (g*8 + i < NUM_KEYS) begin
                        clr[g*8 + i] = rd_vld;
                    end
                end
            end
        end
        if (rd_addr == 8'h7E) begin
            rd_dat = (chg_cnt > 9'd255) ? 8'hFF : chg_cnt[7:0];
        end
        if (rd_addr == 8'h7F) begin
            rd_dat = 8'(NUM_KEYS);
        end
    end

    // Set after clear, so a change landing on the cycle its group is read is kept for the next read.
    assign chg_d = (chg_q & ~clr) | flip;

    always_ff @(posedge clk_g_i) begin
        if (!rstn_g_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            div_q       <= '0;
            tick_q      <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                hist_q[k] <= '0;
            end
            state_q     <= '0;
            chg_q       <= '0;
            irq_q       <= 1'b0;
            mid_frame_q <= 1'b0;
            addr_q      <= 8'h00;
            tx_q        <= 8'h00;
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            tick_q  <= tick;
            for (int k = 0; k < NUM_KEYS; k++) begin
                hist_q[k] <= hist_d[k];
            end
            state_q <= state_d;
            chg_q   <= chg_d;
            irq_q   <= |chg_q;
            if (spi_cs_i) begin
                mid_frame_q <= 1'b0;
            end else if (spi_rx_valid_i) begin
                mid_frame_q <= 1'b1;
                addr_q      <= rd_addr + 8'd1;
                tx_q        <= rd_dat;
            end
        end
    end

    assign spi_tx_byte_o = tx_q;
    assign irq_o         = irq_q;
    assign sample_tick_o = tick_q;

endmodule

// File: tb/tb_spi_keys_regmap.sv
// Bench for spi_keys_regmap: run-length debounce model checked every cycle plus directed literal reads.
module tb_spi_keys_regmap;
    localparam int NK = 68;
    localparam int SD = 8;
    localparam int DB = 4;
    localparam int NG = (NK + 7) / 8;

    logic          clk_g_i = 1'b0;
    logic          rstn_g_i = 1'b0;
    logic [NK-1:0] keys_i = '1;
    logic          spi_cs_i = 1'b1;
    logic          spi_rx_valid_i = 1'b0;
    logic [7:0]    spi_rx_byte_i = 8'h00;
    logic [7:0]    spi_tx_byte_o;
    logic          irq_o;
    logic          sample_tick_o;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] rb [16];

    spi_keys_regmap #(.NUM_KEYS(NK), .SAMPLE_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk_g_i        (clk_g_i),
        .rstn_g_i       (rstn_g_i),
        .keys_i         (keys_i),
        .spi_cs_i       (spi_cs_i),
        .spi_rx_valid_i (spi_rx_valid_i),
        .spi_rx_byte_i  (spi_rx_byte_i),
        .spi_tx_byte_o  (spi_tx_byte_o),
        .irq_o          (irq_o),
        .sample_tick_o  (sample_tick_o)
    );

    always #5 clk_g_i = ~clk_g_i;

    // Model: debounced level, change flag, last sample and its run length per key.
    bit            m_st   [NK];
    bit            m_lat  [NK];
    bit            m_last [NK];
    int            m_run  [NK];
    logic [NK-1:0] m_s1, m_s2;
    int            m_cyc;
    bit            m_first;
    logic [7:0]    m_addr, m_a, e_tx;
    bit            e_irq, e_tick;

    function automatic logic [7:0] model_reg(input logic [7:0] a);
        logic [7:0] r;
        int         cnt;
        r = 8'h00;
        if (int'(a) < NG) begin
            for (int i = 0; i < 8; i++)
                if (8*int'(a) + i < NK) r[i] = m_st[8*int'(a) + i];
        end else if (int'(a) >= 64 && int'(a) < 64 + NG) begin
            for (int i = 0; i < 8; i++)
                if (8*(int'(a) - 64) + i < NK) r[i] = m_lat[8*(int'(a) - 64) + i];
        end else if (a == 8'h7E) begin
            cnt = 0;
            for (int k = 0; k < NK; k++) cnt += int'(m_lat[k]);
            r = (cnt > 255) ? 8'hFF : 8'(cnt);
        end else if (a == 8'h7F) begin
            r = 8'(NK % 256);
        end
        return r;
    endfunction

    always @(negedge clk_g_i) begin
        if (!rstn_g_i) begin
            m_cyc = 0; m_first = 1; m_addr = 8'h00; e_tx = 8'h00;
            e_irq = 0; e_tick = 0; m_s1 = '0; m_s2 = '0;
            for (int k = 0; k < NK; k++) begin
                m_st[k] = 0; m_lat[k] = 0; m_last[k] = 0; m_run[k] = DB;
            end
        end else begin
            e_irq = 0;
            for (int k = 0; k < NK; k++) e_irq |= m_lat[k];
            m_cyc++;
            e_tick = (m_cyc % SD == 0);
            if (spi_cs_i) begin
                m_first = 1;
            end else if (spi_rx_valid_i) begin
                m_a  = m_first ? spi_rx_byte_i : m_addr;
                e_tx = model_reg(m_a);
                if (int'(m_a) >= 64 && int'(m_a) < 64 + NG)
                    for (int i = 0; i < 8; i++)
                        if (8*(int'(m_a) - 64) + i < NK) m_lat[8*(int'(m_a) - 64) + i] = 0;
                m_addr  = m_a + 8'd1;
                m_first = 0;
            end
            if (e_tick) begin
                for (int k = 0; k < NK; k++) begin
                    if (m_s2[k] == m_last[k]) begin
                        if (m_run[k] < DB) m_run[k]++;
                    end else begin
                        m_last[k] = m_s2[k];
                        m_run[k]  = 1;
                    end
                    if (m_run[k] >= DB && m_st[k] != m_last[k]) begin
                        m_st[k]  = m_last[k];
                        m_lat[k] = 1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = keys_i;
        end
        n_chk += 3;
        if (spi_tx_byte_o !== e_tx) begin
            n_err++;
            $display("FAIL tx @%0t: got 0x%02h, expected 0x%02h", $time, spi_tx_byte_o, e_tx);
        end
        if (irq_o !== e_irq) begin
            n_err++;
            $display("FAIL irq @%0t: got %b, expected %b", $time, irq_o, e_irq);
        end
        if (sample_tick_o !== e_tick) begin
            n_err++;
            $display("FAIL tick @%0t: got %b, expected %b", $time, sample_tick_o, e_tick);
        end
    end

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_g_i);
            #1;
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 0;
        for (int i = 0; i < 4*SD; i++) begin
            @(negedge clk_g_i);
            if (sample_tick_o === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_tick: got no sample_tick_o, expected one within %0d cycles", 4*SD);
        end
        #1;
    endtask

    task automatic xfer(input logic [7:0] b, output logic [7:0] r);
        spi_rx_valid_i = 1'b1;
        spi_rx_byte_i  = b;
        cyc(1);
        spi_rx_valid_i = 1'b0;
        spi_rx_byte_i  = 8'h00;
        r = spi_tx_byte_o;
        cyc(1);
    endtask

    task automatic frame(input logic [7:0] a, input int n);
        spi_cs_i = 1'b0;
        cyc(1);
        xfer(a, rb[0]);
        for (int i = 1; i < n; i++) xfer(8'hA5 ^ 8'(i), rb[i]);
        spi_cs_i = 1'b1;
        cyc(1);
    endtask

    initial begin
        logic [7:0] r;
        // Reset with every key pressed
        cyc(5);
        chk8("rst_tx", spi_tx_byte_o, 8'h00);
        chk8("rst_irq", {7'd0, irq_o}, 8'd0);
        chk8("rst_tick", {7'd0, sample_tick_o}, 8'd0);
        rstn_g_i = 1'b1;
        keys_i   = '0;
        frame(8'h00, 1);
        chk8("state0_after_rst", rb[0], 8'h00);

        // Debounce and a short glitch
        wait_tick(); keys_i[3] = 1'b1;
        repeat (4) wait_tick();
        cyc(1);
        chk8("irq_key3", {7'd0, irq_o}, 8'd1);
        frame(8'h00, 1); chk8("state_key3", rb[0], 8'h08);
        frame(8'h40, 1); chk8("chg_key3", rb[0], 8'h08);
        wait_tick(); keys_i[5] = 1'b1;
        repeat (3) wait_tick(); keys_i[5] = 1'b0;
        repeat (2) wait_tick();
        frame(8'h00, 1); chk8("glitch_key5", rb[0], 8'h08);

        // Burst read of all state groups
        wait_tick(); keys_i = '0; keys_i[0] = 1'b1; keys_i[67] = 1'b1;
        repeat (4) wait_tick();
        frame(8'h00, 10);
        chk8("burst_g0", rb[0], 8'h01);
        chk8("burst_g1", rb[1], 8'h00);
        chk8("burst_g7", rb[7], 8'h00);
        chk8("burst_g8_pad", rb[8], 8'h08);
        chk8("burst_unmapped", rb[9], 8'h00);

        // Read-to-clear
        frame(8'h40, NG);
        chk8("clr_g0", rb[0], 8'h09);
        chk8("clr_g8", rb[8], 8'h08);
        cyc(2);
        chk8("irq_cleared", {7'd0, irq_o}, 8'd0);
        wait_tick(); keys_i[10] = 1'b1;
        repeat (4) wait_tick(); keys_i[10] = 1'b0;
        repeat (4) wait_tick();
        cyc(1);
        chk8("irq_key10", {7'd0, irq_o}, 8'd1);
        frame(8'h41, 1); chk8("chg_key10", rb[0], 8'h04);
        cyc(1);
        chk8("irq_fall", {7'd0, irq_o}, 8'd0);
        frame(8'h41, 1); chk8("chg_reread", rb[0], 8'h00);

        // New change on the cycle its group is read
        wait_tick(); keys_i[8] = 1'b1;
        repeat (4) wait_tick();
        keys_i[9] = 1'b1;
        spi_cs_i  = 1'b0;
        cyc(4*SD - 1);
        xfer(8'h41, r);
        chk8("race_read", r, 8'h01);
        spi_cs_i = 1'b1;
        cyc(2);
        chk8("race_irq", {7'd0, irq_o}, 8'd1);
        frame(8'h41, 1); chk8("race_kept", rb[0], 8'h02);
        frame(8'h01, 1); chk8("state_g1", rb[0], 8'h03);

        // Key count, address wrap, change count
        frame(8'h7F, 1); chk8("num_keys", rb[0], 8'h44);
        frame(8'hFE, 3);
        chk8("wrap_fe", rb[0], 8'h00);
        chk8("wrap_ff", rb[1], 8'h00);
        chk8("wrap_00", rb[2], 8'h01);
        wait_tick(); keys_i = '0;
        repeat (4) wait_tick();
        frame(8'h7D, 3);
        chk8("reg_7d", rb[0], 8'h00);
        chk8("chg_count", rb[1], 8'h04);
        chk8("reg_7f_inc", rb[2], 8'h44);

        // Strobe with chip select high is ignored
        spi_rx_valid_i = 1'b1; spi_rx_byte_i = 8'h7E;
        cyc(1);
        spi_rx_valid_i = 1'b0;
        cyc(1);
        chk8("cs_high_ignored", spi_tx_byte_o, 8'h44);

        // Reset in the middle of a frame restarts at the address byte
        spi_cs_i = 1'b0;
        cyc(1);
        xfer(8'h40, r); chk8("pre_rst_chg_g0", r, 8'h01);
        rstn_g_i = 1'b0;
        cyc(1);
        chk8("midframe_rst_tx", spi_tx_byte_o, 8'h00);
        rstn_g_i = 1'b1;
        xfer(8'h7F, r); chk8("post_rst_addr", r, 8'h44);
        spi_cs_i = 1'b1;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
